// File: rtl/keccak_control_if.sv
// Host-side valid/ready streams around the Keccak sequencer.
// The host is the master of din_valid/dout_ready; the controller is the slave.
interface keccak_control_if;
  logic din_valid;
  logic din_ready;
  logic dout_valid;
  logic dout_ready;

  modport master (
    output din_valid,
    output dout_ready,
    input  din_ready,
    input  dout_valid
  );

  modport slave (
    input  din_valid,
    input  dout_ready,
    output din_ready,
    output dout_valid
  );
endinterface

// File: rtl/keccak_control.sv
// Sequencing FSM for keccak_datapath: absorbs header + message words, pads,
// permutes and squeezes output words over valid/ready streams.
module keccak_control #(
  parameter int NR = 24,
  parameter int W  = 64
) (
  input  logic            clk,
  input  logic            rst,
  keccak_control_if.slave hs,
  input  logic [31:0]     c,
  input  logic [31:0]     d,
  input  logic [1:0]      mode,
  output logic            en_len,
  output logic            en_output_len,
  output logic            en_ctr,
  output logic            clr_len,
  output logic            ein,
  output logic            sel_xor,
  output logic            sel_final,
  output logic            wr_state,
  output logic            ld_rdctr,
  output logic            en_rdctr,
  output logic            sel_dec_size,
  output logic            last_word,
  output logic            sel_piso,
  output logic            wr_piso,
  output logic            last_out_word,
  output logic [1:0]      spos,
  output logic [1:0]      mode_ctrl,
  output logic [10:0]     output_size
);

  localparam int         WB          = $clog2(W);
  localparam logic [4:0] RC_PERM_END = 5'(NR - 2);
  localparam logic [4:0] RC_SQZ_END  = 5'(NR - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ABSORB,
    S_LOAD,
    S_PERM,
    S_HOLD,
    S_XOR,
    S_LAST,
    S_PLOAD,
    S_OUT,
    S_SQZ
  } state_t;

  state_t      state;
  logic [4:0]  wi;
  logic [4:0]  rc;
  logic [4:0]  ob;
  logic [26:0] ow;
  logic        pad_done;
  logic        first_blk;

  logic [4:0]  rate;
  logic        is_data;
  logic        is_part;
  logic        slot_go;
  logic        slot_end;
  logic [32:0] d_round;
  logic [26:0] ow_init;
  logic        unused_c_lsb;

  function automatic logic [4:0] rate_of(input logic [1:0] m);
    case (m)
      2'b01:   rate_of = 5'd9;
      2'b10:   rate_of = 5'd21;
      default: rate_of = 5'd17;
    endcase
  endfunction

  assign rate     = rate_of(mode);
  assign is_data  = |c[31:WB];
  assign is_part  = !is_data && (|c[WB-1:3]);
  // Messages are whole bytes, so the sub-byte bits of c carry no information.
  assign unused_c_lsb = ^c[2:0];
  // Data and partial slots wait for a host word; pad-start and zero slots never do.
  assign slot_go  = pad_done || (!is_data && !is_part) || hs.din_valid;
  assign slot_end = (wi == rate - 5'd1);
  assign d_round  = {1'b0, d} + 33'(W - 1);
  assign ow_init  = 27'(d_round >> WB);

  always_comb begin
    hs.din_ready  = 1'b0;
    hs.dout_valid = 1'b0;
    en_len        = 1'b0;
    en_output_len = 1'b0;
    en_ctr        = 1'b0;
    clr_len       = 1'b0;
    ein           = 1'b0;
    sel_xor       = 1'b0;
    sel_final     = 1'b0;
    wr_state      = 1'b0;
    ld_rdctr      = 1'b0;
    en_rdctr      = 1'b0;
    sel_dec_size  = 1'b0;
    last_word     = 1'b0;
    sel_piso      = 1'b0;
    wr_piso       = 1'b0;
    last_out_word = 1'b0;
    spos          = 2'b00;
    mode_ctrl     = 2'b00;
    output_size   = 11'd0;
    if (rst) begin
      mode_ctrl   = mode;
      output_size = d[10:0];
      case (state)
        S_IDLE: begin
          hs.din_ready = 1'b1;
          if (hs.din_valid) begin
            en_len        = 1'b1;
            en_output_len = 1'b1;
          end
        end
        S_ABSORB: begin
          if (pad_done) begin
            spos = 2'b10;
            ein  = 1'b1;
          end else if (is_data) begin
            hs.din_ready = 1'b1;
            if (hs.din_valid) begin
              ein    = 1'b1;
              en_ctr = 1'b1;
            end
          end else if (is_part) begin
            hs.din_ready = 1'b1;
            spos         = 2'b01;
            if (hs.din_valid) begin
              ein     = 1'b1;
              clr_len = 1'b1;
            end
          end else begin
            spos = 2'b11;
            ein  = 1'b1;
          end
          last_word = ein && slot_end && (pad_done || !is_data);
        end
        S_LOAD: begin
          wr_state  = 1'b1;
          sel_xor   = 1'b1;
          sel_final = 1'b1;
          ld_rdctr  = 1'b1;
        end
        S_PERM: begin
          wr_state = 1'b1;
          en_rdctr = 1'b1;
        end
        S_XOR: begin
          wr_state  = 1'b1;
          sel_final = 1'b1;
          ld_rdctr  = 1'b1;
        end
        S_LAST: begin
          wr_state = 1'b1;
          ld_rdctr = 1'b1;
        end
        S_PLOAD: wr_piso = 1'b1;
        S_OUT: begin
          hs.dout_valid = 1'b1;
          last_out_word = (ow == 27'd1);
          if (hs.dout_ready) begin
            wr_piso  = 1'b1;
            sel_piso = 1'b1;
            ld_rdctr = (ow != 27'd1) && (ob + 5'd1 == rate);
          end
        end
        S_SQZ: begin
          wr_state = 1'b1;
          if (rc == RC_SQZ_END) ld_rdctr = 1'b1;
          else                  en_rdctr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wi        <= 5'd0;
      rc        <= 5'd0;
      ob        <= 5'd0;
      ow        <= 27'd0;
      pad_done  <= 1'b0;
      first_blk <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs.din_valid) begin
            state     <= S_ABSORB;
            wi        <= 5'd0;
            pad_done  <= 1'b0;
            first_blk <= 1'b1;
          end
        end
        S_ABSORB: begin
          if (slot_go) begin
            if (!is_data) pad_done <= 1'b1;
            if (slot_end) begin
              wi    <= 5'd0;
              state <= first_blk ? S_LOAD : S_XOR;
            end else begin
              wi <= wi + 5'd1;
            end
          end
        end
        S_LOAD: begin
          first_blk <= 1'b0;
          rc        <= 5'd0;
          state     <= S_PERM;
        end
        S_XOR: begin
          rc    <= 5'd0;
          state <= S_PERM;
        end
        S_PERM: begin
          if (rc == RC_PERM_END) state <= S_HOLD;
          else                   rc    <= rc + 5'd1;
        end
        // Round counter parked at NR-1: either absorb the next block or finish.
        S_HOLD: begin
          if (pad_done) begin
            state <= S_LAST;
          end else begin
            wi    <= 5'd0;
            state <= S_ABSORB;
          end
        end
        S_LAST: begin
          ow    <= ow_init;
          state <= (ow_init == 27'd0) ? S_IDLE : S_PLOAD;
        end
        S_PLOAD: begin
          ob    <= 5'd0;
          state <= S_OUT;
        end
        S_OUT: begin
          if (hs.dout_ready) begin
            ow <= ow - 27'd1;
            ob <= ob + 5'd1;
            if (ow == 27'd1) begin
              state <= S_IDLE;
            end else if (ob + 5'd1 == rate) begin
              rc    <= 5'd0;
              state <= S_SQZ;
            end
          end
        end
        S_SQZ: begin
          if (rc == RC_SQZ_END) state <= S_PLOAD;
          else                  rc    <= rc + 5'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/keccak_control.md
Name: keccak_control

Overview:
- Sequencing FSM that drives keccak_datapath for one hash per header word.
- Accepts a header plus message words over a valid/ready input stream.
- Generates ein/pad/permutation/PISO controls, then streams the squeezed output words back over a valid/ready output stream.
- Sits between the host interface and keccak_datapath; consumes the datapath's c, d and mode outputs.

Parameters:
- NR, 24, Keccak-f rounds per permutation.
- W, 64, datapath word width in bits (only 64 supported).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- din_valid  in  1  host word available on datapath din.
- din_ready  out  1  controller accepts the current din word.
- dout_valid  out  1  datapath dout word valid.
- dout_ready  in  1  host takes the dout word.
- c  in  32  remaining message bits (datapath).
- d  in  32  requested output bits (datapath).
- mode  in  2  00/11 rate 17 words, 01 rate 9, 10 rate 21.
- en_len, en_output_len, en_ctr, clr_len, ein, sel_xor, sel_final, wr_state, ld_rdctr, en_rdctr, sel_dec_size, last_word, sel_piso, wr_piso, last_out_word  out  1 each  datapath controls.
- spos  out  2  pad control.
- mode_ctrl  out  2  equals mode.
- output_size  out  11  d[10:0].

Behaviour:
- Reset (rst low, async):
  - FSM goes to IDLE; all counters clear.
  - Every output is 0, including din_ready and dout_valid.
- IDLE:
  - din_ready=1.
  - On din_valid: en_len=1 and en_output_len=1 (header: [31:0] c, [60:32] d, [62:61] mode); go to ABSORB.
  - Header bit 63 is ignored.
- ABSORB: word index wi runs 0..r-1, where r is the rate from mode.
  - Each slot asserts ein=1 exactly once. The slot type is decided from c and pad_done:
  - c>=64: data word. din_ready=1, spos=00. ein=en_ctr=1 only in the din_valid cycle (c-=64, sel_dec_size=0). Stall while din_valid=0.
  - 0<c<64: partial word. din_ready=1, spos=01, ein=1, clr_len=1; set pad_done.
  - c==0 and !pad_done: pad-start word. No input consumed, spos=11, ein=1; set pad_done.
  - pad_done: zero word, spos=10, ein=1.
  - wi==r-1 with pad_done (after this slot's update): last_word=1.
  - c[2:0] is ignored (byte messages only).
  - After the slot with wi==r-1, go to LOAD if this is the first block, else to XOR.
- LOAD (1 cycle): wr_state=1, sel_xor=1, sel_final=1, ld_rdctr=1 (state := block). Go to PERM.
- PERM: NR-1 cycles with wr_state=1, en_rdctr=1, sel_final=0. Then go to HOLD.
- HOLD (round counter at NR-1, state frozen):
  - If !pad_done: go to ABSORB with wi=0.
  - Else: go to LAST.
- XOR (1 cycle): round NR-1 with xor. wr_state=1, sel_final=1, sel_xor=0, ld_rdctr=1. Go to PERM.
- LAST (1 cycle): wr_state=1, sel_final=0, ld_rdctr=1.
  - Load remaining output words: ow = ceil(d/64).
  - If ow==0 go to IDLE, else go to PLOAD.
- PLOAD (1 cycle): wr_piso=1, sel_piso=0; ob=0. Go to OUT.
- OUT:
  - dout_valid=1; last_out_word=1 when ow==1.
  - On dout_ready: wr_piso=1, sel_piso=1, ow-=1, ob+=1.
  - If ow reaches 0: go to IDLE.
  - Else if ob==r: go to SQZ (ld_rdctr=1).
- SQZ: NR-1 cycles of PERM-style rounds (sel_final=0), then one LAST-style round. Then go to PLOAD.
- Timing:
  - Each block costs r absorb slots (plus input stalls) + 24 permutation cycles.
  - First dout_valid appears 2 cycles after the final round.
- Simultaneous din_valid and FSM state change: a word is consumed only when din_ready=1 and din_valid=1 in the same cycle.
- Reset mid-operation: abort to IDLE with no flush. The next LOAD with sel_xor=1 overwrites the stale datapath state.

Test Plan:
- Mode 00, c=0, d=256:
  - Zero din words consumed after the header; 17 ein pulses.
  - Slot 0 spos=11; slots 1-16 spos=10; last_word only on slot 16.
  - LOAD, then 24 round cycles.
  - 4 dout words; last_out_word on the 4th; back to IDLE.
- Mode 00, c=1088, d=256:
  - 17 data words, each with en_ctr.
  - HOLD goes to ABSORB; block 2 is pad-start + 16 zero words with last_word.
  - XOR cycle with sel_final=1, sel_xor=0.
  - Total permutations = 2.
- Mode 01, c=200:
  - Slots 0-2 data words; slot 3 partial with spos=01 and clr_len=1.
  - Slots 4-8 spos=10; last_word on slot 8.
- Mode 10, d=1600 (25 words):
  - 21 words, then SQZ of 24 cycles with no dout_valid.
  - PLOAD, then 4 words; last_out_word on word 25.
- Backpressure:
  - Random din_valid gaps: ein never pulses on a data slot without din_valid.
  - Random dout_ready gaps: wr_piso never pulses in OUT without dout_ready.
  - Output data matches the no-gap run.
- rst low during PERM cycle 10: all outputs 0 immediately.
  - After release: IDLE with din_ready=1.
  - A new header produces a correct digest.
